data_mem_stack: RTL and testbench

Parametrised single-port data memory with a built-in hardware stack pointer, for the RNBIP-2 memory stage. It executes one LOAD, STORE, PUSH or POP command per clock. The stack pointer is held locally and incremented or decremented by the block, so the datapath no longer muxes SP against R0. Reads are registered with a valid strobe, and stack overflow, stack underflow and bad-SP-load events raise sticky error flags.

---
 rtl/data_mem_pkg.sv | 16 +
 rtl/data_mem_ram.sv | 27 ++
 rtl/data_mem_stack.sv | 96 +++++++++
 tb/tb_data_mem_stack.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared command encoding and stack-pointer range helper for the RNBIP-2 data memory.
package data_mem_pkg;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_STORE = 2'd1;
  localparam logic [1:0] OP_PUSH  = 2'd2;
  localparam logic [1:0] OP_POP   = 2'd3;

  // Legal sp values span STACK_BOT-1 (full) up to STACK_TOP (empty); the +1 avoids underflow at bot.
  function automatic logic sp_in_range(input int unsigned sp_val,
                                       input int unsigned top,
                                       input int unsigned bot);
    return ((sp_val + 1) >= bot) && (sp_val <= top);
  endfunction

endpackage

// File: rtl/data_mem_ram.sv
// Single-port RAM: synchronous write, registered read gated by a read enable.
module data_mem_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Output register holds its value between reads so the last result stays visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_stack.sv
// Data memory with a local downward-growing hardware stack pointer and sticky error flags.
module data_mem_stack
  import data_mem_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int STACK_TOP = 2**ADDR_W - 1,
  parameter int STACK_BOT = 2**(ADDR_W-1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              sp_load,
  input  logic [ADDR_W-1:0] sp_in,
  input  logic              err_clr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [ADDR_W-1:0] sp,
  output logic              empty,
  output logic              full,
  output logic              err_ovf,
  output logic              err_udf,
  output logic              err_sp
);

  localparam logic [ADDR_W-1:0] SP_EMPTY = ADDR_W'(STACK_TOP);
  localparam logic [ADDR_W-1:0] SP_FULL  = ADDR_W'(STACK_BOT - 1);

  logic              is_load, is_store, is_push, is_pop;
  logic              push_ok, pop_ok, sp_ld_ok;
  logic              ovf_evt, udf_evt, sp_evt;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] sp_inc, sp_nxt, ram_addr;

  assign empty = (sp == SP_EMPTY);
  assign full  = (sp == SP_FULL);

  always_comb begin
    is_load  = cmd_valid && (cmd_op == OP_LOAD);
    is_store = cmd_valid && (cmd_op == OP_STORE);
    is_push  = cmd_valid && (cmd_op == OP_PUSH);
    is_pop   = cmd_valid && (cmd_op == OP_POP);
    push_ok  = is_push && !full;
    pop_ok   = is_pop && !empty;
    ovf_evt  = is_push && full;
    udf_evt  = is_pop && empty;
    sp_ld_ok = sp_load && sp_in_range(32'(sp_in), STACK_TOP, STACK_BOT);
    sp_evt   = sp_load && !sp_ld_ok;
    sp_inc   = sp + ADDR_W'(1);
    ram_we   = is_store || push_ok;
    ram_re   = is_load || pop_ok;
    // sp already names the next free slot, so PUSH writes at sp and POP reads one above it.
    ram_addr = addr;
    if (is_push)     ram_addr = sp;
    else if (is_pop) ram_addr = sp_inc;
    // The command always sees the old sp; a legal sp_load replaces whatever it would do to sp.
    sp_nxt = sp;
    if (push_ok)     sp_nxt = sp - ADDR_W'(1);
    else if (pop_ok) sp_nxt = sp_inc;
    if (sp_ld_ok)    sp_nxt = sp_in;
  end

  data_mem_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  // An error event on the same edge as err_clr keeps its flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp      <= SP_EMPTY;
      rvalid  <= 1'b0;
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
      err_sp  <= 1'b0;
    end else begin
      sp      <= sp_nxt;
      rvalid  <= ram_re;
      err_ovf <= ovf_evt || (err_ovf && !err_clr);
      err_udf <= udf_evt || (err_udf && !err_clr);
      err_sp  <= sp_evt  || (err_sp  && !err_clr);
    end
  end

endmodule

// File: tb/tb_data_mem_stack.sv
// Bench for data_mem_stack: directed scenarios plus randomized traffic against a reference model.
module tb_data_mem_stack;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, sp_load, err_clr;
  logic [1:0] cmd_op;
  logic [7:0] addr, wdata, sp_in;
  logic [7:0] rdata, sp;
  logic       rvalid, empty, full, err_ovf, err_udf, err_sp;

  logic        c_valid, c_sp_load, c_err_clr;
  logic [1:0]  c_op;
  logic [3:0]  c_addr, c_sp_in, c_sp;
  logic [15:0] c_wdata, c_rdata;
  logic        c_rvalid, c_empty, c_full, c_ovf, c_udf, c_sperr;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0] m_mem [256];
  bit         m_wr  [256];
  int         m_sp;
  logic [7:0] m_rdata;
  bit         m_rd_known, m_rvalid, m_ovf, m_udf, m_sperr;

  always #5 clk = ~clk;

  data_mem_stack dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .addr(addr),
    .wdata(wdata), .sp_load(sp_load), .sp_in(sp_in), .err_clr(err_clr), .rdata(rdata),
    .rvalid(rvalid), .sp(sp), .empty(empty), .full(full), .err_ovf(err_ovf),
    .err_udf(err_udf), .err_sp(err_sp)
  );

  data_mem_stack #(.DATA_W(16), .ADDR_W(4), .STACK_BOT(8)) dut16 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(c_valid), .cmd_op(c_op), .addr(c_addr),
    .wdata(c_wdata), .sp_load(c_sp_load), .sp_in(c_sp_in), .err_clr(c_err_clr), .rdata(c_rdata),
    .rvalid(c_rvalid), .sp(c_sp), .empty(c_empty), .full(c_full), .err_ovf(c_ovf),
    .err_udf(c_udf), .err_sp(c_sperr)
  );

  task automatic model_reset();
    m_sp = 255; m_rdata = 8'h00; m_rd_known = 1; m_rvalid = 0;
    m_ovf = 0; m_udf = 0; m_sperr = 0;
  endtask

  // Stack of 128 slots living at 128..255; sp is the next free slot.
  task automatic model_step(input bit v, input logic [1:0] op, input logic [7:0] a,
                            input logic [7:0] d, input bit sl, input logic [7:0] si, input bit clr);
    int  nsp = m_sp;
    bit  oe = 0, ue = 0, se = 0;
    m_rvalid = 0;
    if (v) begin
      case (op)
        2'd0: begin m_rdata = m_mem[a]; m_rd_known = m_wr[a]; m_rvalid = 1; end
        2'd1: begin m_mem[a] = d; m_wr[a] = 1; end
        2'd2: if (m_sp == 127) oe = 1;
              else begin m_mem[m_sp] = d; m_wr[m_sp] = 1; nsp = m_sp - 1; end
        default: if (m_sp == 255) ue = 1;
              else begin m_rdata = m_mem[m_sp+1]; m_rd_known = m_wr[m_sp+1]; m_rvalid = 1; nsp = m_sp + 1; end
      endcase
    end
    if (sl) begin
      if (int'(si) >= 127) nsp = int'(si);
      else se = 1;
    end
    m_sp = nsp;
    m_ovf = oe || (m_ovf && !clr);
    m_udf = ue || (m_udf && !clr);
    m_sperr = se || (m_sperr && !clr);
  endtask

  // Drives one cycle on the 8-bit DUT starting at posedge+1; returns at the next posedge+1.
  task automatic cyc(input bit v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] d,
                     input bit sl = 0, input logic [7:0] si = 8'h00, input bit clr = 0);
    cmd_valid = v; cmd_op = op; addr = a; wdata = d; sp_load = sl; sp_in = si; err_clr = clr;
    @(posedge clk); #1;
    model_step(v, op, a, d, sl, si, clr);
    cmd_valid = 0; sp_load = 0; err_clr = 0;
  endtask

  task automatic cyc16(input bit v, input logic [1:0] op, input logic [3:0] a, input logic [15:0] d);
    c_valid = v; c_op = op; c_addr = a; c_wdata = d;
    @(posedge clk); #1;
    c_valid = 0;
  endtask

  task automatic test_reset();
    cyc(1, 2'd3, 8'h00, 8'h00);
    cyc(1, 2'd2, 8'h00, 8'h99);
    cyc(1, 2'd0, 8'hFF, 8'h00);
    rst_n = 0;
    #2;
    if (sp !== 8'd255) begin n_fail++; $display("FAIL reset_sp: got %0d expected 255", sp); end n_tests++;
    if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end n_tests++;
    if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end n_tests++;
    if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end n_tests++;
    if (rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00", rdata); end n_tests++;
    if ({err_ovf, err_udf, err_sp} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {err_ovf, err_udf, err_sp}); end n_tests++;
    if ({c_sp, c_empty, c_full} !== {4'd15, 1'b1, 1'b0}) begin n_fail++; $display("FAIL reset_dut16: got sp=%0d e=%b f=%b expected 15 1 0", c_sp, c_empty, c_full); end n_tests++;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_load_store();
    cyc(1, 2'd1, 8'h10, 8'hA5);
    if (rvalid !== 1'b0) begin n_fail++; $display("FAIL store_rvalid: got %b expected 0", rvalid); end n_tests++;
    cyc(1, 2'd0, 8'h10, 8'h00);
    if (rvalid !== 1'b1 || rdata !== 8'hA5) begin n_fail++; $display("FAIL load_rdata: got rv=%b %h expected 1 a5", rvalid, rdata); end n_tests++;
    cyc(0, 2'd0, 8'h00, 8'h00);
    if (rvalid !== 1'b0 || rdata !== 8'hA5) begin n_fail++; $display("FAIL load_pulse_hold: got rv=%b %h expected 0 a5", rvalid, rdata); end n_tests++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_pop [3] = '{8'h33, 8'h22, 8'h11};
    cyc(1, 2'd2, 8'h00, 8'h11);
    cyc(1, 2'd2, 8'h00, 8'h22);
    cyc(1, 2'd2, 8'h00, 8'h33);
    if (sp !== 8'd252) begin n_fail++; $display("FAIL push3_sp: got %0d expected 252", sp); end n_tests++;
    for (int i = 0; i < 3; i++) begin
      cyc(1, 2'd3, 8'h00, 8'h00);
      if (rvalid !== 1'b1 || rdata !== exp_pop[i]) begin n_fail++; $display("FAIL pop%0d: got rv=%b %h expected 1 %h", i, rvalid, rdata, exp_pop[i]); end n_tests++;
    end
    if (sp !== 8'd255 || empty !== 1'b1) begin n_fail++; $display("FAIL pop3_sp: got %0d e=%b expected 255 1", sp, empty); end n_tests++;
    cyc(1, 2'd2, 8'h00, 8'h6B);
    cyc(1, 2'd3, 8'h00, 8'h00);
    if (rdata !== 8'h6B || sp !== 8'd255) begin n_fail++; $display("FAIL push_then_pop: got %h sp=%0d expected 6b 255", rdata, sp); end n_tests++;
  endtask

  task automatic test_overflow();
    cyc(1, 2'd1, 8'd127, 8'h5C);
    for (int i = 0; i < 128; i++) begin
      cyc(1, 2'd2, 8'h00, 8'(i));
      if (i == 126 && full !== 1'b0) begin n_fail++; $display("FAIL early_full: got %b expected 0", full); end
      if (i == 126) n_tests++;
    end
    if (full !== 1'b1 || sp !== 8'd127 || err_ovf !== 1'b0) begin n_fail++; $display("FAIL fill: got f=%b sp=%0d ovf=%b expected 1 127 0", full, sp, err_ovf); end n_tests++;
    cyc(1, 2'd2, 8'h00, 8'hEE);
    if (err_ovf !== 1'b1 || sp !== 8'd127) begin n_fail++; $display("FAIL ovf: got ovf=%b sp=%0d expected 1 127", err_ovf, sp); end n_tests++;
    cyc(1, 2'd0, 8'd127, 8'h00);
    if (rdata !== 8'h5C) begin n_fail++; $display("FAIL ovf_nowrite: got %h expected 5c", rdata); end n_tests++;
    cyc(1, 2'd3, 8'h00, 8'h00);
    if (rdata !== 8'd127) begin n_fail++; $display("FAIL first_pop: got %h expected 7f", rdata); end n_tests++;
    for (int i = 0; i < 127; i++) cyc(1, 2'd3, 8'h00, 8'h00);
    if (rdata !== 8'h00 || empty !== 1'b1) begin n_fail++; $display("FAIL drain: got %h e=%b expected 00 1", rdata, empty); end n_tests++;
    cyc(1, 2'd3, 8'h00, 8'h00);
    if (err_udf !== 1'b1 || rvalid !== 1'b0 || sp !== 8'd255) begin n_fail++; $display("FAIL udf: got udf=%b rv=%b sp=%0d expected 1 0 255", err_udf, rvalid, sp); end n_tests++;
    cyc(0, 2'd0, 8'h00, 8'h00, 0, 8'h00, 1);
    if (err_ovf !== 1'b0 || err_udf !== 1'b0) begin n_fail++; $display("FAIL err_clr: got ovf=%b udf=%b expected 0 0", err_ovf, err_udf); end n_tests++;
    cyc(1, 2'd3, 8'h00, 8'h00, 0, 8'h00, 1);
    if (err_udf !== 1'b1) begin n_fail++; $display("FAIL clr_vs_event: got %b expected 1", err_udf); end n_tests++;
    cyc(0, 2'd0, 8'h00, 8'h00, 0, 8'h00, 1);
  endtask

  task automatic test_sp_load();
    cyc(0, 2'd0, 8'h00, 8'h00, 1, 8'h40);
    if (err_sp !== 1'b1 || sp !== 8'd255) begin n_fail++; $display("FAIL sp_bad: got err=%b sp=%0d expected 1 255", err_sp, sp); end n_tests++;
    cyc(1, 2'd2, 8'h00, 8'h77, 1, 8'hF0, 1);
    if (sp !== 8'hF0 || err_sp !== 1'b0) begin n_fail++; $display("FAIL sp_load_push: got sp=%h err=%b expected f0 0", sp, err_sp); end n_tests++;
    cyc(1, 2'd0, 8'hFF, 8'h00);
    if (rdata !== 8'h77) begin n_fail++; $display("FAIL push_old_sp: got %h expected 77", rdata); end n_tests++;
    cyc(1, 2'd2, 8'h00, 8'h12, 1, 8'h10);
    if (sp !== 8'hEF || err_sp !== 1'b1) begin n_fail++; $display("FAIL bad_load_push: got sp=%h err=%b expected ef 1", sp, err_sp); end n_tests++;
    cyc(0, 2'd0, 8'h00, 8'h00, 1, 8'h7F, 1);
    if (full !== 1'b1 || sp !== 8'h7F || err_sp !== 1'b0) begin n_fail++; $display("FAIL load_bot: got f=%b sp=%h err=%b expected 1 7f 0", full, sp, err_sp); end n_tests++;
    cyc(0, 2'd0, 8'h00, 8'h00, 1, 8'h7E);
    if (sp !== 8'h7F || err_sp !== 1'b1) begin n_fail++; $display("FAIL load_below: got sp=%h err=%b expected 7f 1", sp, err_sp); end n_tests++;
    cyc(0, 2'd0, 8'h00, 8'h00, 1, 8'hFF, 1);
  endtask

  task automatic test_param16();
    logic [15:0] ref16 [16];
    for (int i = 0; i < 8; i++) cyc16(1, 2'd2, 4'h0, 16'(16'hB000 + i));
    if (c_full !== 1'b1 || c_sp !== 4'd7) begin n_fail++; $display("FAIL p16_full: got f=%b sp=%0d expected 1 7", c_full, c_sp); end n_tests++;
    cyc16(1, 2'd2, 4'h0, 16'hDEAD);
    if (c_ovf !== 1'b1 || c_sp !== 4'd7) begin n_fail++; $display("FAIL p16_ovf: got ovf=%b sp=%0d expected 1 7", c_ovf, c_sp); end n_tests++;
    cyc16(1, 2'd3, 4'h0, 16'h0);
    if (c_rdata !== 16'hB007 || c_rvalid !== 1'b1) begin n_fail++; $display("FAIL p16_pop: got %h rv=%b expected b007 1", c_rdata, c_rvalid); end n_tests++;
    for (int i = 0; i < 16; i++) begin
      ref16[i] = 16'($urandom);
      cyc16(1, 2'd1, 4'(i), ref16[i]);
    end
    for (int i = 0; i < 16; i++) begin
      cyc16(1, 2'd0, 4'(i), 16'h0);
      if (c_rdata !== ref16[i] || c_rvalid !== 1'b1) begin n_fail++; $display("FAIL p16_rt[%0d]: got %h rv=%b expected %h 1", i, c_rdata, c_rvalid, ref16[i]); end n_tests++;
    end
  endtask

  task automatic test_random();
    logic [1:0] op;
    logic [7:0] si;
    bit         sl, clr;
    for (int i = 0; i < 256; i++) cyc(1, 2'd1, 8'(i), 8'($urandom));
    for (int i = 0; i < 1500; i++) begin
      op  = 2'($urandom_range(0, 3));
      sl  = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 15) == 0);
      si  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(127, 255)) : 8'($urandom);
      cyc($urandom_range(0, 5) != 0, op, 8'($urandom), 8'($urandom), sl, si, clr);
      if (sp !== 8'(m_sp) || empty !== (m_sp == 255) || full !== (m_sp == 127)) begin n_fail++; $display("FAIL rnd_sp[%0d]: got sp=%0d e=%b f=%b expected %0d", i, sp, empty, full, m_sp); end n_tests++;
      if (rvalid !== m_rvalid) begin n_fail++; $display("FAIL rnd_rvalid[%0d]: got %b expected %b", i, rvalid, m_rvalid); end n_tests++;
      if ({err_ovf, err_udf, err_sp} !== {m_ovf, m_udf, m_sperr}) begin n_fail++; $display("FAIL rnd_flags[%0d]: got %b expected %b", i, {err_ovf, err_udf, err_sp}, {m_ovf, m_udf, m_sperr}); end n_tests++;
      if (m_rd_known) begin
        if (rdata !== m_rdata) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h expected %h", i, rdata, m_rdata); end
        n_tests++;
      end
    end
  endtask

  initial begin
    rst_n = 0;
    cmd_valid = 0; cmd_op = 2'd0; addr = 8'h00; wdata = 8'h00; sp_load = 0; sp_in = 8'h00; err_clr = 0;
    c_valid = 0; c_op = 2'd0; c_addr = 4'h0; c_wdata = 16'h0; c_sp_load = 0; c_sp_in = 4'h0; c_err_clr = 0;
    for (int i = 0; i < 256; i++) begin m_mem[i] = 8'h00; m_wr[i] = 0; end
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    test_reset();
    test_load_store();
    test_back_to_back();
    test_overflow();
    test_sp_load();
    test_param16();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
